// File: rtl/rover_pio_pkg.sv
// Shared constants for the rover PIO: register word addresses and edge-select encodings.
package rover_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/rover_pio_edge_cap.sv
// Input synchroniser, previous-sample register, edge select and sticky edge capture.
// A W1C clear and a fresh edge on the same bit in the same cycle leave the bit set.
module rover_pio_edge_cap
  import rover_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] in_sync_o,
  output logic [WIDTH-1:0] edge_cap_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] inPrev_q;
  logic [WIDTH-1:0] edgeCap_q;
  logic [WIDTH-1:0] edgeCap_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;

  assign in_sync_o  = sync_q[SYNC_STAGES-1];
  assign edge_cap_o = edgeCap_q;

  // Shift the asynchronous inputs through the synchroniser chain and keep the last synced sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      inPrev_q <= '0;
    end else begin
      sync_q[0] <= in_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      inPrev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pick the configured edge and fold it into the sticky capture, set taking priority over clear.
  always_comb begin
    rise = in_sync_o & ~inPrev_q;
    fall = ~in_sync_o & inPrev_q;
    evt  = '0;
    if (EDGE_TYPE == EDGE_RISE) begin
      evt = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      evt = fall;
    end else begin
      evt = rise | fall;
    end
    edgeCap_d = (edgeCap_q & ~clr_i) | evt;
  end

  // Capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgeCap_q <= '0;
    end else begin
      edgeCap_q <= edgeCap_d;
    end
  end

endmodule

// File: rtl/rover_pio_bidir.sv
// Avalon-MM slave bidirectional PIO: per-bit direction, atomic set/clear, edge capture,
// maskable level interrupt and registered read data with a fixed latency of one cycle.
module rover_pio_bidir
  import rover_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic             wrEn;
  logic             rdEn;
  logic [WIDTH-1:0] wData;
  logic [WIDTH-1:0] dataOut_q, dataOut_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irqMask_q, irqMask_d;
  logic             irq_q, irq_d;
  logic [31:0]      readData_q, readData_d;
  logic [WIDTH-1:0] readSel;
  logic [WIDTH-1:0] edgeClr;
  logic [WIDTH-1:0] inSync;
  logic [WIDTH-1:0] edgeCap;
  logic             unused_wdata;

  assign wrEn         = chipselect & ~write_n;
  assign rdEn         = chipselect & ~read_n;
  assign wData        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign edgeClr      = (wrEn && address == ADDR_EDGECAP) ? wData : '0;

  assign out_port = dataOut_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;
  assign readdata = readData_q;

  rover_pio_edge_cap #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_cap (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_i       (in_port),
    .clr_i      (edgeClr),
    .in_sync_o  (inSync),
    .edge_cap_o (edgeCap)
  );

  // Register writes, plus read mux sampled from pre-write state so a same-cycle write is not seen.
  always_comb begin
    dataOut_d  = dataOut_q;
    dir_d      = dir_q;
    irqMask_d  = irqMask_q;
    readSel    = '0;
    readData_d = readData_q;
    irq_d      = |(edgeCap & irqMask_q);
    if (wrEn) begin
      case (address)
        ADDR_DATA:    dataOut_d = wData;
        ADDR_DIR:     dir_d     = wData;
        ADDR_IRQMASK: irqMask_d = wData;
        ADDR_OUTSET:  dataOut_d = dataOut_q | wData;
        ADDR_OUTCLR:  dataOut_d = dataOut_q & ~wData;
        default:      ;
      endcase
    end
    case (address)
      ADDR_DATA:    readSel = (dataOut_q & dir_q) | (inSync & ~dir_q);
      ADDR_DIR:     readSel = dir_q;
      ADDR_IRQMASK: readSel = irqMask_q;
      ADDR_EDGECAP: readSel = edgeCap;
      default:      readSel = '0;
    endcase
    if (rdEn) begin
      readData_d = '0;
      readData_d[WIDTH-1:0] = readSel;
    end
  end

  // Control/status registers, interrupt flop and read data holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataOut_q  <= RESET_OUT;
      dir_q      <= RESET_DIR;
      irqMask_q  <= '0;
      irq_q      <= 1'b0;
      readData_q <= '0;
    end else begin
      dataOut_q  <= dataOut_d;
      dir_q      <= dir_d;
      irqMask_q  <= irqMask_d;
      irq_q      <= irq_d;
      readData_q <= readData_d;
    end
  end

endmodule

// File: tb/tb_rover_pio_bidir.sv
// Scoreboard bench for rover_pio_bidir: two instances (rising edge / 2-stage sync and
// any edge / 3-stage sync) share one bus; a reference model queues per-cycle expectations
// and a negedge monitor pops and compares them.
module tb_rover_pio_bidir;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdataR, readdataA;
  logic [7:0]  outPortR, outPortA, oePortR, oePortA;
  logic        irqR, irqA;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  outV;
    logic [7:0]  oeV;
    logic        irq0;
    logic        irq1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } expT;

  expT expQ[$];

  logic [7:0]  mOut, mDir, mMask;
  logic [7:0]  mCap[2];
  logic        mIrq[2];
  logic [31:0] mRd[2];
  logic [7:0]  hist[8];
  logic [7:0]  pinCur;

  rover_pio_bidir #(
    .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'hF0), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dutR (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdataR),
    .in_port(in_port), .out_port(outPortR), .oe_port(oePortR), .irq(irqR)
  );

  rover_pio_bidir #(
    .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'hF0), .EDGE_TYPE(2), .SYNC_STAGES(3)
  ) dutA (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdataA),
    .in_port(in_port), .out_port(outPortA), .oe_port(oePortA), .irq(irqA)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expV);
    checks++;
    if (act !== expV) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, expV, $time);
    end
  endtask

  task automatic modelReset();
    mOut  = 8'hA5;
    mDir  = 8'hF0;
    mMask = 8'h00;
    for (int k = 0; k < 2; k++) begin
      mCap[k] = 8'h00;
      mIrq[k] = 1'b0;
      mRd[k]  = 32'h0;
    end
    for (int i = 0; i < 8; i++) hist[i] = 8'h00;
  endtask

  // Drive one bus cycle, advance the reference model across the clock edge, queue the expectation.
  task automatic applyStimulus(input logic c, input logic [2:0] a, input logic w, input logic r,
                               input logic [31:0] wd, input logic [7:0] pin);
    expT        e;
    logic [7:0] sy, pv, ev, clr, rv;
    logic       wrAct, rdAct;
    int         s;
    chipselect = c;
    address    = a;
    write_n    = ~w;
    read_n     = ~r;
    writedata  = wd;
    in_port    = pin;
    pinCur     = pin;
    @(posedge clk);
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pin;
    wrAct = c & w;
    rdAct = c & r;
    clr   = (wrAct && a == 3'd3) ? wd[7:0] : 8'h00;
    for (int k = 0; k < 2; k++) begin
      s  = (k == 0) ? 2 : 3;
      sy = hist[s];
      pv = hist[s+1];
      if (rdAct) begin
        case (a)
          3'd0:    rv = (mOut & mDir) | (sy & ~mDir);
          3'd1:    rv = mDir;
          3'd2:    rv = mMask;
          3'd3:    rv = mCap[k];
          default: rv = 8'h00;
        endcase
        mRd[k] = {24'h0, rv};
      end
      mIrq[k] = |(mCap[k] & mMask);
      ev      = (k == 0) ? (sy & ~pv) : (sy ^ pv);
      mCap[k] = (mCap[k] & ~clr) | ev;
    end
    if (wrAct) begin
      case (a)
        3'd0:    mOut  = wd[7:0];
        3'd1:    mDir  = wd[7:0];
        3'd2:    mMask = wd[7:0];
        3'd4:    mOut  = mOut | wd[7:0];
        3'd5:    mOut  = mOut & ~wd[7:0];
        default: ;
      endcase
    end
    e.outV = mOut;
    e.oeV  = mDir;
    e.irq0 = mIrq[0];
    e.irq1 = mIrq[1];
    e.rd0  = mRd[0];
    e.rd1  = mRd[1];
    expQ.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, pinCur);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, 1'b1, 1'b0, d, pinCur);
  endtask

  task automatic rd(input logic [2:0] a);
    applyStimulus(1'b1, a, 1'b0, 1'b1, 32'h0, pinCur);
  endtask

  // Monitor: every clock the DUT presents outputs, pop the queued expectation and compare.
  always @(negedge clk) begin
    expT e;
    if (reset_n && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("out_port_r", {24'h0, outPortR}, {24'h0, e.outV});
      checkOutput("out_port_a", {24'h0, outPortA}, {24'h0, e.outV});
      checkOutput("oe_port_r",  {24'h0, oePortR},  {24'h0, e.oeV});
      checkOutput("oe_port_a",  {24'h0, oePortA},  {24'h0, e.oeV});
      checkOutput("irq_r",      {31'h0, irqR},     {31'h0, e.irq0});
      checkOutput("irq_a",      {31'h0, irqA},     {31'h0, e.irq1});
      checkOutput("readdata_r", readdataR,         e.rd0);
      checkOutput("readdata_a", readdataA,         e.rd1);
    end
  end

  // Directed scenarios, mid-operation reset, then randomized traffic.
  initial begin
    int drain;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    address    = 3'd0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;
    pinCur     = 8'h00;
    modelReset();

    #12;
    checkOutput("reset_out_port", {24'h0, outPortR}, 32'h000000A5);
    checkOutput("reset_oe_port",  {24'h0, oePortR},  32'h000000F0);
    checkOutput("reset_irq",      {31'h0, irqR},     32'h0);
    checkOutput("reset_readdata", readdataR,         32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    rd(3'd1);
    checkOutput("read_dir_after_reset", readdataR, 32'h000000F0);

    wr(3'd0, 32'hFFFF_FF0F);
    checkOutput("data_write", {24'h0, outPortR}, 32'h0F);
    wr(3'd4, 32'h0000_0030);
    checkOutput("outset", {24'h0, outPortR}, 32'h3F);
    wr(3'd5, 32'h0000_0005);
    checkOutput("outclr", {24'h0, outPortR}, 32'h3A);

    wr(3'd1, 32'h0F);
    wr(3'd0, 32'hFF);
    pinCur = 8'h50;
    idle(4);
    rd(3'd0);
    checkOutput("mixed_data_read_r", readdataR, 32'h5F);
    checkOutput("mixed_data_read_a", readdataA, 32'h5F);

    pinCur = 8'h00;
    idle(6);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 8'h01);
    idle(1);
    idle(1);
    checkOutput("irq_not_yet", {31'h0, irqR}, 32'h0);
    idle(1);
    checkOutput("irq_asserted", {31'h0, irqR}, 32'h1);
    idle(2);
    wr(3'd3, 32'h01);
    idle(2);
    checkOutput("irq_cleared", {31'h0, irqR}, 32'h0);

    wr(3'd3, 32'hFF);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 8'h05);
    idle(1);
    wr(3'd3, 32'h04);
    rd(3'd3);
    checkOutput("w1c_set_wins", {31'h0, readdataR[2]}, 32'h1);

    idle(4);
    wr(3'd3, 32'hFF);
    pinCur = 8'h0D;
    idle(3);
    pinCur = 8'h05;
    idle(6);
    rd(3'd3);
    checkOutput("pulse_capture_r", readdataR, 32'h08);
    checkOutput("pulse_capture_a", readdataA, 32'h08);

    wr(3'd2, 32'h08);
    rd(3'd1);
    idle(1);
    checkOutput("irq_before_reset", {31'h0, irqA}, 32'h1);

    @(negedge clk);
    #1;
    chipselect = 1'b1;
    address    = 3'd3;
    read_n     = 1'b0;
    write_n    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_irq_r",      {31'h0, irqR},     32'h0);
    checkOutput("midreset_irq_a",      {31'h0, irqA},     32'h0);
    checkOutput("midreset_readdata_r", readdataR,         32'h0);
    checkOutput("midreset_out_port",   {24'h0, outPortR}, 32'hA5);
    checkOutput("midreset_oe_port",    {24'h0, oePortA},  32'hF0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
    rd(3'd3);
    checkOutput("edgecap_after_reset", readdataA, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] pin;
      pin = pinCur;
      if ($urandom_range(3) == 0) pin = 8'($urandom);
      applyStimulus(1'($urandom_range(7) != 0), 3'($urandom_range(7)),
                    1'($urandom), 1'($urandom), $urandom, pin);
    end

    drain = 0;
    while (expQ.size() > 0 && drain < 5) begin
      @(negedge clk);
      #1;
      drain++;
    end
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
